multicycle_controller: RTL and testbench

- Multicycle sequencer for the single-issue datapath: register file, ALU, data memory and sign-extend unit.
- Accepts one 32-bit MIPS-format instruction at a time over a valid/ready handshake and latches it into an internal instruction register (IR).
- Steps the instruction through DECODE/EXECUTE/MEM/WRITEBACK, driving the register-file, ALU and memory control lines each cycle.
- Reports completion, branch outcome, illegal opcodes and a retired-instruction count.

---
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: latches one MIPS instruction per IDLE visit and walks it
// through DECODE/EXECUTE/MEM/WRITEBACK, driving register-file, ALU and memory controls.
module multicycle_controller #(
    parameter int COUNT_WIDTH    = 16,
    parameter bit ILLEGAL_COUNTS = 1'b0
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   instrValid,
    input  logic [31:0]            instr,
    output logic                   instrReady,
    input  logic                   zero,
    output logic [4:0]             readReg1,
    output logic [4:0]             readReg2,
    output logic [4:0]             writeReg,
    output logic                   regWrite,
    output logic [3:0]             aluOp,
    output logic                   aluSrcImm,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   memToReg,
    output logic [15:0]            immediate,
    output logic                   busy,
    output logic                   done,
    output logic                   branchTaken,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [31:0]            ir_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    logic [5:0] op;
    logic [5:0] funct;
    logic       r_legal;
    logic [3:0] r_alu_op;
    logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_legal;
    logic       unused_shamt;

    assign op           = ir_reg[31:26];
    assign funct        = ir_reg[5:0];
    assign unused_shamt = ^ir_reg[10:6];

    always_comb begin
        r_legal  = 1'b0;
        r_alu_op = 4'd0;
        case (funct)
            6'h20: begin r_legal = 1'b1; r_alu_op = 4'd2;  end
            6'h22: begin r_legal = 1'b1; r_alu_op = 4'd6;  end
            6'h24: begin r_legal = 1'b1; r_alu_op = 4'd0;  end
            6'h25: begin r_legal = 1'b1; r_alu_op = 4'd1;  end
            6'h27: begin r_legal = 1'b1; r_alu_op = 4'd12; end
            6'h2A: begin r_legal = 1'b1; r_alu_op = 4'd7;  end
            default: ;
        endcase
    end

    assign is_rtype = (op == 6'h00) && r_legal;
    assign is_addi  = (op == 6'h08);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_legal = is_rtype || is_addi || is_lw || is_sw || is_beq;

    // Ready is masked by reset so nothing looks acceptable while held in reset.
    assign instrReady = (state_reg == IDLE) && resetN;
    assign readReg1   = ir_reg[25:21];
    assign readReg2   = ir_reg[20:16];
    assign immediate  = ir_reg[15:0];
    assign busy       = (state_reg != IDLE);
    assign instrCount = count_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg <= IDLE;
            ir_reg    <= 32'h0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (instrReady && instrValid) begin
                ir_reg <= instr;
            end
            if (done || (ILLEGAL_COUNTS && illegal)) begin
                count_reg <= count_reg + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        writeReg    = 5'd0;
        regWrite    = 1'b0;
        aluOp       = 4'd0;
        aluSrcImm   = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        done        = 1'b0;
        branchTaken = 1'b0;
        illegal     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (instrValid) state_next = DECODE;
            end
            DECODE: begin
                if (is_legal) begin
                    state_next = EXECUTE;
                end else begin
                    illegal    = 1'b1;
                    state_next = IDLE;
                end
            end
            EXECUTE: begin
                if (is_rtype) begin
                    aluOp      = r_alu_op;
                    state_next = WRITEBACK;
                end else if (is_beq) begin
                    aluOp       = 4'd6;
                    branchTaken = zero;
                    done        = 1'b1;
                    state_next  = IDLE;
                end else begin
                    aluOp      = 4'd2;
                    aluSrcImm  = 1'b1;
                    state_next = (is_lw || is_sw) ? MEM : WRITEBACK;
                end
            end
            MEM: begin
                aluOp     = 4'd2;
                aluSrcImm = 1'b1;
                if (is_lw) begin
                    memRead    = 1'b1;
                    state_next = WRITEBACK;
                end else begin
                    memWrite   = 1'b1;
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITEBACK: begin
                regWrite   = 1'b1;
                writeReg   = is_rtype ? ir_reg[15:11] : ir_reg[20:16];
                memToReg   = is_lw;
                memRead    = is_lw;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a default instance for the main
// scenarios and a 2-bit-counter instance (illegals counted) for wrap-around.
module tb_multicycle_controller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetN;
    logic        instrValid, zero;
    logic [31:0] instr;
    logic        instrReady, regWrite, aluSrcImm, memRead, memWrite, memToReg;
    logic        busy, done, branchTaken, illegal;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [3:0]  aluOp;
    logic [15:0] immediate, instrCount;

    logic        instrValid_w, zero_w;
    logic [31:0] instr_w;
    logic        instrReady_w, regWrite_w, aluSrcImm_w, memRead_w, memWrite_w, memToReg_w;
    logic        busy_w, done_w, branchTaken_w, illegal_w;
    logic [4:0]  readReg1_w, readReg2_w, writeReg_w;
    logic [3:0]  aluOp_w;
    logic [15:0] immediate_w;
    logic [1:0]  instrCount_w;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = 16'd0;

    logic [5:0]  fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0]  op_tab [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};
    logic [1:0]  wrap_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    multicycle_controller dut (
        .clock(clock), .resetN(resetN), .instrValid(instrValid), .instr(instr),
        .instrReady(instrReady), .zero(zero), .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .regWrite(regWrite), .aluOp(aluOp), .aluSrcImm(aluSrcImm),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .immediate(immediate),
        .busy(busy), .done(done), .branchTaken(branchTaken), .illegal(illegal),
        .instrCount(instrCount)
    );

    multicycle_controller #(.COUNT_WIDTH(2), .ILLEGAL_COUNTS(1'b1)) dut_w (
        .clock(clock), .resetN(resetN), .instrValid(instrValid_w), .instr(instr_w),
        .instrReady(instrReady_w), .zero(zero_w), .readReg1(readReg1_w), .readReg2(readReg2_w),
        .writeReg(writeReg_w), .regWrite(regWrite_w), .aluOp(aluOp_w), .aluSrcImm(aluSrcImm_w),
        .memRead(memRead_w), .memWrite(memWrite_w), .memToReg(memToReg_w), .immediate(immediate_w),
        .busy(busy_w), .done(done_w), .branchTaken(branchTaken_w), .illegal(illegal_w),
        .instrCount(instrCount_w)
    );

    // Present one word for a single accept edge; returns just after that edge.
    task automatic issue(input logic [31:0] w);
        @(negedge clock); instrValid = 1'b1; instr = w;
        @(posedge clock); #1; instrValid = 1'b0; instr = 32'h0;
    endtask

    task automatic issue_w(input logic [31:0] w);
        @(negedge clock); instrValid_w = 1'b1; instr_w = w;
        @(posedge clock); #1; instrValid_w = 1'b0; instr_w = 32'h0;
    endtask

    task automatic test_reset();
        n_cmp++; if (instrReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", instrReady); end
        n_cmp++; if (busy !== 1'b0 || regWrite !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl busy=%b regWrite=%b done=%b exp=000", busy, regWrite, done); end
        n_cmp++; if (instrCount !== 16'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", instrCount); end
        @(negedge clock); resetN = 1'b1; #1;
        n_cmp++; if (instrReady !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b exp=1", instrReady); end
        issue(32'h00221820);
        repeat (4) @(negedge clock);
        n_cmp++; if (instrCount !== 16'd1) begin n_bad++; $display("FAIL rst_precount got=%0d exp=1", instrCount); end
        issue(32'h00221820);
        repeat (2) @(negedge clock);
        n_cmp++; if (busy !== 1'b1 || aluOp !== 4'd2) begin n_bad++; $display("FAIL rst_mid_exec busy=%b aluOp=%0d exp=1/2", busy, aluOp); end
        resetN = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0 || regWrite !== 1'b0 || aluOp !== 4'd0 || instrReady !== 1'b0) begin n_bad++; $display("FAIL rst_async busy=%b regWrite=%b aluOp=%0d ready=%b exp=0/0/0/0", busy, regWrite, aluOp, instrReady); end
        n_cmp++; if (instrCount !== 16'd0) begin n_bad++; $display("FAIL rst_async_count got=%0d exp=0", instrCount); end
        exp_count = 16'd0;
        @(negedge clock); resetN = 1'b1; #1;
        n_cmp++; if (instrReady !== 1'b1) begin n_bad++; $display("FAIL rst_rerelease_ready got=%b exp=1", instrReady); end
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || regWrite !== 1'b0) begin n_bad++; $display("FAIL rst_settled busy=%b regWrite=%b exp=0/0", busy, regWrite); end
    endtask

    task automatic test_rtype();
        for (int k = 0; k < 6; k++) begin
            issue({26'h0008860, fn_tab[k]});
            @(negedge clock);
            n_cmp++; if (readReg1 !== 5'd1 || readReg2 !== 5'd2) begin n_bad++; $display("FAIL r_decode_regs k=%0d rr1=%0d rr2=%0d exp=1/2", k, readReg1, readReg2); end
            n_cmp++; if (aluOp !== 4'd0 || regWrite !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL r_decode_ctrl k=%0d aluOp=%0d rw=%b done=%b busy=%b exp=0/0/0/1", k, aluOp, regWrite, done, busy); end
            @(negedge clock);
            n_cmp++; if (aluOp !== op_tab[k] || aluSrcImm !== 1'b0 || regWrite !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL r_exec k=%0d aluOp=%0d srcImm=%b rw=%b done=%b exp=%0d/0/0/0", k, aluOp, aluSrcImm, regWrite, done, op_tab[k]); end
            @(negedge clock);
            n_cmp++; if (regWrite !== 1'b1 || writeReg !== 5'd3 || done !== 1'b1 || memToReg !== 1'b0 || aluOp !== 4'd0) begin n_bad++; $display("FAIL r_wb k=%0d rw=%b wr=%0d done=%b m2r=%b aluOp=%0d exp=1/3/1/0/0", k, regWrite, writeReg, done, memToReg, aluOp); end
            exp_count++;
            @(negedge clock);
            n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || writeReg !== 5'd0 || instrCount !== exp_count) begin n_bad++; $display("FAIL r_retire k=%0d busy=%b done=%b wr=%0d cnt=%0d exp=0/0/0/%0d", k, busy, done, writeReg, instrCount, exp_count); end
        end
    endtask

    task automatic test_lw_sw();
        logic rw_seen;
        issue(32'h8C450004);
        @(negedge clock);
        @(negedge clock);
        n_cmp++; if (aluOp !== 4'd2 || aluSrcImm !== 1'b1 || memRead !== 1'b0 || immediate !== 16'h0004) begin n_bad++; $display("FAIL lw_exec aluOp=%0d srcImm=%b mr=%b imm=%h exp=2/1/0/0004", aluOp, aluSrcImm, memRead, immediate); end
        @(negedge clock);
        n_cmp++; if (memRead !== 1'b1 || aluOp !== 4'd2 || aluSrcImm !== 1'b1 || done !== 1'b0 || regWrite !== 1'b0) begin n_bad++; $display("FAIL lw_mem mr=%b aluOp=%0d srcImm=%b done=%b rw=%b exp=1/2/1/0/0", memRead, aluOp, aluSrcImm, done, regWrite); end
        @(negedge clock);
        n_cmp++; if (regWrite !== 1'b1 || writeReg !== 5'd5 || memToReg !== 1'b1 || memRead !== 1'b1 || done !== 1'b1) begin n_bad++; $display("FAIL lw_wb rw=%b wr=%0d m2r=%b mr=%b done=%b exp=1/5/1/1/1", regWrite, writeReg, memToReg, memRead, done); end
        exp_count++;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || memRead !== 1'b0 || instrCount !== exp_count) begin n_bad++; $display("FAIL lw_retire busy=%b mr=%b cnt=%0d exp=0/0/%0d", busy, memRead, instrCount, exp_count); end

        rw_seen = 1'b0;
        issue(32'hAC450008);
        @(negedge clock); rw_seen = rw_seen | regWrite;
        @(negedge clock); rw_seen = rw_seen | regWrite;
        n_cmp++; if (aluOp !== 4'd2 || aluSrcImm !== 1'b1 || memWrite !== 1'b0) begin n_bad++; $display("FAIL sw_exec aluOp=%0d srcImm=%b mw=%b exp=2/1/0", aluOp, aluSrcImm, memWrite); end
        @(negedge clock); rw_seen = rw_seen | regWrite;
        n_cmp++; if (memWrite !== 1'b1 || done !== 1'b1 || memRead !== 1'b0) begin n_bad++; $display("FAIL sw_mem mw=%b done=%b mr=%b exp=1/1/0", memWrite, done, memRead); end
        exp_count++;
        @(negedge clock); rw_seen = rw_seen | regWrite;
        n_cmp++; if (busy !== 1'b0 || memWrite !== 1'b0 || instrCount !== exp_count) begin n_bad++; $display("FAIL sw_retire busy=%b mw=%b cnt=%0d exp=0/0/%0d", busy, memWrite, instrCount, exp_count); end
        n_cmp++; if (rw_seen !== 1'b0) begin n_bad++; $display("FAIL sw_regwrite got=%b exp=0", rw_seen); end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            zero = (t == 0);
            issue(32'h10220003);
            @(negedge clock);
            n_cmp++; if (branchTaken !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL beq_decode t=%0d bt=%b done=%b exp=0/0", t, branchTaken, done); end
            @(negedge clock);
            n_cmp++; if (aluOp !== 4'd6 || aluSrcImm !== 1'b0 || done !== 1'b1 || branchTaken !== (t == 0)) begin n_bad++; $display("FAIL beq_exec t=%0d aluOp=%0d srcImm=%b done=%b bt=%b exp=6/0/1/%b", t, aluOp, aluSrcImm, done, branchTaken, (t == 0)); end
            exp_count++;
            @(negedge clock);
            n_cmp++; if (busy !== 1'b0 || branchTaken !== 1'b0 || instrCount !== exp_count) begin n_bad++; $display("FAIL beq_retire t=%0d busy=%b bt=%b cnt=%0d exp=0/0/%0d", t, busy, branchTaken, instrCount, exp_count); end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal_handshake();
        issue(32'h00221821);
        @(negedge clock);
        n_cmp++; if (illegal !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ill_funct illegal=%b done=%b exp=1/0", illegal, done); end
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || illegal !== 1'b0 || instrCount !== exp_count) begin n_bad++; $display("FAIL ill_funct_after busy=%b illegal=%b cnt=%0d exp=0/0/%0d", busy, illegal, instrCount, exp_count); end

        @(negedge clock); instrValid = 1'b1; instr = 32'hFC000000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            n_cmp++; if (instrReady !== (i % 2 == 0) || illegal !== (i % 2 == 1) || done !== 1'b0) begin n_bad++; $display("FAIL ill_hold i=%0d ready=%b illegal=%b done=%b exp=%b/%b/0", i, instrReady, illegal, done, (i % 2 == 0), (i % 2 == 1)); end
            n_cmp++; if (instrCount !== exp_count) begin n_bad++; $display("FAIL ill_count i=%0d got=%0d exp=%0d", i, instrCount, exp_count); end
        end
        instr = 32'h00221820;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); #1;
            n_cmp++; if (instrReady !== (i % 4 == 0) || busy !== (i % 4 != 0) || done !== (i % 4 == 3)) begin n_bad++; $display("FAIL hs_hold i=%0d ready=%b busy=%b done=%b exp=%b/%b/%b", i, instrReady, busy, done, (i % 4 == 0), (i % 4 != 0), (i % 4 == 3)); end
        end
        instrValid = 1'b0; instr = 32'h0;
        exp_count = exp_count + 16'd2;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || instrCount !== exp_count) begin n_bad++; $display("FAIL hs_count busy=%b cnt=%0d exp=0/%0d", busy, instrCount, exp_count); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 5; k++) begin
            issue_w(32'h20010001);
            @(negedge clock);
            @(negedge clock);
            n_cmp++; if (aluOp_w !== 4'd2 || aluSrcImm_w !== 1'b1) begin n_bad++; $display("FAIL addi_exec k=%0d aluOp=%0d srcImm=%b exp=2/1", k, aluOp_w, aluSrcImm_w); end
            @(negedge clock);
            n_cmp++; if (regWrite_w !== 1'b1 || writeReg_w !== 5'd1 || done_w !== 1'b1 || memToReg_w !== 1'b0) begin n_bad++; $display("FAIL addi_wb k=%0d rw=%b wr=%0d done=%b m2r=%b exp=1/1/1/0", k, regWrite_w, writeReg_w, done_w, memToReg_w); end
            @(negedge clock);
            n_cmp++; if (instrCount_w !== wrap_tab[k]) begin n_bad++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, instrCount_w, wrap_tab[k]); end
        end
        issue_w(32'hFC000000);
        @(negedge clock);
        n_cmp++; if (illegal_w !== 1'b1 || done_w !== 1'b0) begin n_bad++; $display("FAIL wrap_illegal illegal=%b done=%b exp=1/0", illegal_w, done_w); end
        @(negedge clock);
        n_cmp++; if (instrCount_w !== 2'd2) begin n_bad++; $display("FAIL wrap_illegal_count got=%0d exp=2", instrCount_w); end
    endtask

    initial begin
        resetN       = 1'b0;
        instrValid   = 1'b0; instr   = 32'h0; zero   = 1'b0;
        instrValid_w = 1'b0; instr_w = 32'h0; zero_w = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_rtype();
        test_lw_sw();
        test_beq();
        test_illegal_handshake();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
